// File: rtl/lsu_stage_if.sv
// -----------------------------------------------------------------------------
// lsu_stage_if
//   Bundles the three handshakes of the load/store stage:
//     - execute -> LSU operation handshake (in_valid/in_ready + operands)
//     - LSU -> data-memory request/response port
//     - LSU -> write-back handshake (out_valid/out_ready + result)
//   Modports:
//     master : the lsu_stage itself (accepts ops, drives memory requests,
//              produces the write-back value)
//     slave  : the surrounding environment (execute, memory, write-back)
// -----------------------------------------------------------------------------
interface lsu_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // execute -> LSU
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       EXU_data;
  logic [DATA_W-1:0] gpr_rdata2_in;
  logic [3:0]        lsu_op;
  logic              lsu_uns;

  // LSU <-> data memory
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  // LSU -> write-back
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] wb_data;
  logic              misalign;

  modport master (
    input  in_valid, EXU_data, gpr_rdata2_in, lsu_op, lsu_uns,
    output in_ready,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output out_valid, wb_data, misalign,
    input  out_ready
  );

  modport slave (
    output in_valid, EXU_data, gpr_rdata2_in, lsu_op, lsu_uns,
    input  in_ready,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  out_valid, wb_data, misalign,
    output out_ready
  );
endinterface

// File: rtl/lsu_stage.sv
// -----------------------------------------------------------------------------
// lsu_stage
//   Load/store stage sitting directly behind the execute unit. Each accepted
//   operation is either passed straight through to write-back, flagged as
//   misaligned, or turned into exactly one data-memory request/response
//   transaction. Only one operation is in flight at a time.
//
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : lsu_stage_if.master
//              in_valid/in_ready, EXU_data, gpr_rdata2_in, lsu_op, lsu_uns
//              mem_req_valid/mem_req_ready, mem_addr, mem_wen, mem_wdata,
//              mem_wmask, mem_resp_valid, mem_rdata
//              out_valid/out_ready, wb_data, misalign
//
//   lsu_op: bit3 = load, bit2 = store (both set -> pass-through),
//           bits[1:0] = size (00 byte, 01 half, 10 word, 11 always misaligned)
// -----------------------------------------------------------------------------
module lsu_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  lsu_stage_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // operation context captured at acceptance
  logic [1:0]        r_off;
  logic [1:0]        r_size;
  logic              r_load;
  logic              r_uns;

  // memory request registers, stable for the whole REQ phase
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_wen;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [3:0]        r_mem_wmask;

  // write-back registers, stable for the whole DONE phase
  logic [DATA_W-1:0] r_wb_data;
  logic              r_misalign;

  logic w_is_ld;
  logic w_is_st;
  logic w_is_mem;
  logic w_misal;
  logic w_in_ready;
  logic w_req_valid;
  logic w_out_valid;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  function automatic logic f_misaligned(input logic [1:0] size,
                                        input logic [1:0] off);
    logic m;
    case (size)
      2'b00:   m = 1'b0;
      2'b01:   m = off[0];
      2'b10:   m = (off != 2'b00);
      default: m = 1'b1;
    endcase
    f_misaligned = m;
  endfunction

  // Replicate store data across every lane it could land in; the mask picks
  // the lane, so the data itself does not need to be shifted by the offset.
  function automatic logic [DATA_W-1:0] f_st_wdata(input logic [1:0]        size,
                                                   input logic [DATA_W-1:0] rs2);
    logic [DATA_W-1:0] d;
    case (size)
      2'b00:   d = {4{rs2[7:0]}};
      2'b01:   d = {2{rs2[15:0]}};
      default: d = rs2;
    endcase
    f_st_wdata = d;
  endfunction

  function automatic logic [3:0] f_st_wmask(input logic [1:0] size,
                                            input logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    f_st_wmask = m;
  endfunction

  // Bring the addressed lane down to bit 0, then sign/zero extend.
  function automatic logic [DATA_W-1:0] f_ld_ext(input logic [DATA_W-1:0] rdata,
                                                 input logic [1:0]        off,
                                                 input logic [1:0]        size,
                                                 input logic              uns);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] r;
    sh = rdata >> {off, 3'b000};
    case (size)
      2'b00:   r = uns ? {{(DATA_W-8){1'b0}},   sh[7:0]}
                       : {{(DATA_W-8){sh[7]}},  sh[7:0]};
      2'b01:   r = uns ? {{(DATA_W-16){1'b0}},  sh[15:0]}
                       : {{(DATA_W-16){sh[15]}}, sh[15:0]};
      default: r = sh;
    endcase
    f_ld_ext = r;
  endfunction

  // ---------------------------------------------------------------------------
  // Operation decode (only meaningful while IDLE)
  // ---------------------------------------------------------------------------
  // both load and store set is illegal and degrades to pass-through
  assign w_is_ld  = bus.lsu_op[3] & ~bus.lsu_op[2];
  assign w_is_st  = bus.lsu_op[2] & ~bus.lsu_op[3];
  assign w_is_mem = w_is_ld | w_is_st;
  assign w_misal  = f_misaligned(bus.lsu_op[1:0], bus.EXU_data[1:0]);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_req_valid = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_nxt = (w_is_mem && !w_misal) ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        w_req_valid = 1'b1;
        if (bus.mem_req_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      // a response can only be consumed here, so one arriving alongside the
      // request handshake or after a reset is dropped automatically
      S_WAIT: begin
        if (bus.mem_resp_valid) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand capture, memory request and write-back registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_off       <= 2'b00;
      r_size      <= 2'b00;
      r_load      <= 1'b0;
      r_uns       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wen   <= 1'b0;
      r_mem_wdata <= '0;
      r_mem_wmask <= 4'b0000;
      r_wb_data   <= '0;
      r_misalign  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_off  <= bus.EXU_data[1:0];
            r_size <= bus.lsu_op[1:0];
            r_load <= w_is_ld;
            r_uns  <= bus.lsu_uns;
            if (!w_is_mem) begin
              r_wb_data  <= bus.EXU_data;
              r_misalign <= 1'b0;
            end else if (w_misal) begin
              r_wb_data  <= '0;
              r_misalign <= 1'b1;
            end else begin
              r_mem_addr  <= {bus.EXU_data[ADDR_W-1:2], 2'b00};
              r_mem_wen   <= w_is_st;
              r_mem_wdata <= w_is_st ? f_st_wdata(bus.lsu_op[1:0], bus.gpr_rdata2_in) : '0;
              r_mem_wmask <= w_is_st ? f_st_wmask(bus.lsu_op[1:0], bus.EXU_data[1:0]) : 4'b0000;
              r_misalign  <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (bus.mem_resp_valid) begin
            // a store's write ack carries no data; write-back gets zero
            r_wb_data <= r_load ? f_ld_ext(bus.mem_rdata, r_off, r_size, r_uns) : '0;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_misalign <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.mem_req_valid = w_req_valid;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wen       = r_mem_wen;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.mem_wmask     = r_mem_wmask;
  assign bus.out_valid     = w_out_valid;
  assign bus.wb_data       = r_wb_data;
  assign bus.misalign      = r_misalign;

endmodule

// File: tb/tb_lsu_stage.sv
// -----------------------------------------------------------------------------
// tb_lsu_stage
//   Directed bench for lsu_stage. Expected write-back results are pushed to a
//   scoreboard queue when an operation is driven and popped when the stage
//   hands the result to write-back. The memory side is played by the bench.
// -----------------------------------------------------------------------------
module tb_lsu_stage;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  lsu_stage_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  lsu_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] wb;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid       = 1'b0;
    bus.EXU_data       = 32'h0;
    bus.gpr_rdata2_in  = 32'h0;
    bus.lsu_op         = 4'h0;
    bus.lsu_uns        = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = 32'h0;
    bus.out_ready      = 1'b0;
  endtask

  // Drives one operation from IDLE and plays memory and write-back.
  // Called at a negedge; returns at a negedge with the stage back in IDLE.
  // lat = cycles between the accepting edge and the first out_valid sample.
  task automatic run_op(input string tag, input logic [3:0] op, input logic uns,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [31:0] rdata, input int req_stall,
                        input int out_stall, input bit exp_req,
                        input logic exp_wen, input logic [3:0] exp_wmask,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_wb,
                        input logic exp_mis, output int lat);
    int   cyc;
    int   rs;
    int   os;
    int   n_hs;
    bit   hs_now;
    bit   done;
    exp_t e;
    cyc = 0; rs = 0; os = 0; n_hs = 0; hs_now = 1'b0; done = 1'b0; lat = -1;

    chk($sformatf("%s.in_ready_idle", tag), 32'(bus.in_ready), 32'd1);
    bus.in_valid      = 1'b1;
    bus.lsu_op        = op;
    bus.lsu_uns       = uns;
    bus.EXU_data      = addr;
    bus.gpr_rdata2_in = rs2;
    e.wb  = exp_wb;
    e.mis = exp_mis;
    sb.push_back(e);
    @(negedge clk);
    // operands are scrubbed so a stage that fails to latch them shows it
    idle_inputs();

    while (!done && cyc < 60) begin
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_rdata      = 32'h0;
      bus.out_ready      = 1'b0;
      if (hs_now) begin
        hs_now             = 1'b0;
        n_hs++;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = rdata;
      end
      chk($sformatf("%s.in_ready_busy", tag), 32'(bus.in_ready), 32'd0);
      if (!exp_req) chk($sformatf("%s.no_req", tag), 32'(bus.mem_req_valid), 32'd0);
      if (bus.mem_req_valid) begin
        chk($sformatf("%s.mem_addr", tag), bus.mem_addr, {addr[31:2], 2'b00});
        chk($sformatf("%s.mem_wen", tag), 32'(bus.mem_wen), 32'(exp_wen));
        chk($sformatf("%s.mem_wmask", tag), 32'(bus.mem_wmask), 32'(exp_wmask));
        if (exp_wen) chk($sformatf("%s.mem_wdata", tag), bus.mem_wdata, exp_wdata);
        // stray response while the request is pending must be ignored
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = ~rdata;
        if (rs < req_stall) rs++;
        else begin
          bus.mem_req_ready = 1'b1;
          hs_now            = 1'b1;
        end
      end
      if (bus.out_valid) begin
        if (lat < 0) lat = cyc;
        if (sb.size() == 0) begin
          chk($sformatf("%s.sb_empty", tag), 32'd1, 32'(sb.size()));
          done = 1'b1;
        end else begin
          chk($sformatf("%s.wb_data", tag), bus.wb_data, sb[0].wb);
          chk($sformatf("%s.misalign", tag), 32'(bus.misalign), 32'(sb[0].mis));
          if (os < out_stall) os++;
          else begin
            bus.out_ready = 1'b1;
            void'(sb.pop_front());
            done = 1'b1;
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    idle_inputs();
    chk($sformatf("%s.timeout", tag), 32'(done), 32'd1);
    chk($sformatf("%s.req_handshakes", tag), 32'(n_hs), exp_req ? 32'd1 : 32'd0);
    chk($sformatf("%s.out_valid_clr", tag), 32'(bus.out_valid), 32'd0);
    chk($sformatf("%s.misalign_clr", tag), 32'(bus.misalign), 32'd0);
    chk($sformatf("%s.in_ready_back", tag), 32'(bus.in_ready), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk($sformatf("%s.in_ready", tag), 32'(bus.in_ready), 32'd1);
    chk($sformatf("%s.mem_req_valid", tag), 32'(bus.mem_req_valid), 32'd0);
    chk($sformatf("%s.mem_wen", tag), 32'(bus.mem_wen), 32'd0);
    chk($sformatf("%s.mem_addr", tag), bus.mem_addr, 32'd0);
    chk($sformatf("%s.mem_wdata", tag), bus.mem_wdata, 32'd0);
    chk($sformatf("%s.mem_wmask", tag), 32'(bus.mem_wmask), 32'd0);
    chk($sformatf("%s.wb_data", tag), bus.wb_data, 32'd0);
    chk($sformatf("%s.out_valid", tag), 32'(bus.out_valid), 32'd0);
    chk($sformatf("%s.misalign", tag), 32'(bus.misalign), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected end before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("reset_async");
    repeat (2) @(negedge clk);
    chk_reset_vals("reset_held");
    rst_n = 1'b1;
    @(negedge clk);

    // pass-through, result one cycle after acceptance
    run_op("pass", 4'b0000, 1'b0, 32'h1234_5678, 32'h0, 32'h0, 0, 0,
           1'b0, 1'b0, 4'h0, 32'h0, 32'h1234_5678, 1'b0, lat);
    chk("pass.latency", 32'(lat), 32'd0);

    // load+store both set: illegal, treated as pass-through
    run_op("illegal", 4'b1110, 1'b0, 32'hCAFE_F00D, 32'h5555_5555, 32'h0, 0, 0,
           1'b0, 1'b0, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0, lat);
    chk("illegal.latency", 32'(lat), 32'd0);

    // signed / unsigned byte load from lane 3
    run_op("lb", 4'b1000, 1'b0, 32'h8000_0003, 32'h0, 32'h80FF_0000, 0, 0,
           1'b1, 1'b0, 4'h0, 32'h0, 32'hFFFF_FF80, 1'b0, lat);
    chk("lb.latency", 32'(lat), 32'd2);
    run_op("lbu", 4'b1000, 1'b1, 32'h8000_0003, 32'h0, 32'h80FF_0000, 0, 0,
           1'b1, 1'b0, 4'h0, 32'h0, 32'h0000_0080, 1'b0, lat);

    // half store into upper half
    run_op("sh", 4'b0101, 1'b0, 32'h8000_0002, 32'hDEAD_BEEF, 32'h0, 0, 0,
           1'b1, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0, lat);

    // backpressure on both the request and write-back sides
    run_op("sw_stall", 4'b0110, 1'b0, 32'h8000_0010, 32'h1122_3344, 32'h0, 5, 3,
           1'b1, 1'b1, 4'b1111, 32'h1122_3344, 32'h0, 1'b0, lat);
    chk("sw_stall.latency", 32'(lat), 32'd7);

    // misaligned word load: no memory traffic
    run_op("lw_misal", 4'b1010, 1'b0, 32'h8000_0006, 32'h0, 32'h0, 0, 0,
           1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, lat);
    chk("lw_misal.latency", 32'(lat), 32'd0);

    // size 11 is always misaligned, even on an aligned address
    run_op("sz11_misal", 4'b1011, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 0, 0,
           1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, lat);

    // signed half load from upper half, unsigned half from lower half
    run_op("lh", 4'b1001, 1'b0, 32'h8000_0002, 32'h0, 32'h8001_1234, 0, 0,
           1'b1, 1'b0, 4'h0, 32'h0, 32'hFFFF_8001, 1'b0, lat);
    run_op("lhu", 4'b1001, 1'b1, 32'h8000_0000, 32'h0, 32'h0000_F00F, 0, 0,
           1'b1, 1'b0, 4'h0, 32'h0, 32'h0000_F00F, 1'b0, lat);

    // byte store into lane 1
    run_op("sb", 4'b0100, 1'b0, 32'h8000_0001, 32'h0000_00A5, 32'h0, 0, 0,
           1'b1, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0, 1'b0, lat);

    // aligned word load with a short request stall
    run_op("lw", 4'b1010, 1'b0, 32'h8000_0004, 32'h0, 32'h89AB_CDEF, 2, 0,
           1'b1, 1'b0, 4'h0, 32'h0, 32'h89AB_CDEF, 1'b0, lat);
    chk("lw.latency", 32'(lat), 32'd4);

    // reset while waiting for a load response
    bus.in_valid = 1'b1;
    bus.lsu_op   = 4'b1010;
    bus.EXU_data = 32'h8000_0100;
    @(negedge clk);
    idle_inputs();
    chk("rstwait.in_req", 32'(bus.mem_req_valid), 32'd1);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    chk("rstwait.req_dropped", 32'(bus.mem_req_valid), 32'd0);
    chk("rstwait.busy", 32'(bus.in_ready), 32'd0);
    chk("rstwait.addr_before", bus.mem_addr, 32'h8000_0100);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rstwait");
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rstwait.after_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rstwait.after_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rstwait.after_wb", bus.wb_data, 32'd0);
      @(negedge clk);
    end

    chk("sb.drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
